// File: rtl/pcie_msi_pkg.sv
// Shared widths, FSM state type and message-data merge helper for the MSI responder.
package pcie_msi_pkg;

  localparam int MSI_VEC_W   = 5;
  localparam int MSI_NVEC    = 32;
  localparam int MSI_MME_MAX = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    ACK  = 2'd2
  } msi_resp_state_t;

  // Clamp multiple-message-enable to the number of vector bits we actually have.
  function automatic logic [2:0] msi_eff_mme(input logic [2:0] mme);
    return (mme > 3'(MSI_MME_MAX)) ? 3'(MSI_MME_MAX) : mme;
  endfunction

  function automatic logic [MSI_VEC_W-1:0] msi_vec_mask(input logic [2:0] m);
    logic [MSI_VEC_W:0] full;
    full = ((MSI_VEC_W+1)'(1) << m) - (MSI_VEC_W+1)'(1);
    return full[MSI_VEC_W-1:0];
  endfunction

  // Low m bits of the message data carry the vector; upper bits come from the base.
  function automatic logic [31:0] msi_merge_data(input logic [15:0] base,
                                                 input logic [2:0] m,
                                                 input logic [MSI_VEC_W-1:0] v);
    logic [15:0] low_mask;
    low_mask = (16'd1 << m) - 16'd1;
    return {16'h0000, (base & ~low_mask) | ({11'd0, v} & low_mask)};
  endfunction

endpackage

// File: rtl/pcie_msi_pend_arb.sv
// Per-vector MSI pending register with a lowest-index picker over unmasked pending bits.
module pcie_msi_pend_arb
  import pcie_msi_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [MSI_VEC_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [MSI_VEC_W-1:0] clr_idx,
  input  logic [MSI_NVEC-1:0]  mask,
  output logic [MSI_NVEC-1:0]  pending,
  output logic                 any,
  output logic [MSI_VEC_W-1:0] idx
);

  logic [MSI_NVEC-1:0] pending_reg;
  logic [MSI_NVEC-1:0] pending_next;
  logic [MSI_NVEC-1:0] set_dec;
  logic [MSI_NVEC-1:0] clr_dec;
  logic [MSI_NVEC-1:0] eligible;

  for (genvar gi = 0; gi < MSI_NVEC; gi++) begin : g_dec
    assign set_dec[gi] = set_en && (set_idx == MSI_VEC_W'(gi));
    assign clr_dec[gi] = clr_en && (clr_idx == MSI_VEC_W'(gi));
  end

  assign pending_next = (pending_reg | set_dec) & ~clr_dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign pending  = pending_reg;
  assign eligible = pending_reg & ~mask;
  assign any      = |eligible;

  // Scan from the top so the lowest set index is the last (winning) assignment.
  always_comb begin
    idx = '0;
    for (int i = MSI_NVEC - 1; i >= 0; i--) begin
      if (eligible[i]) idx = MSI_VEC_W'(i);
    end
  end

endmodule

// File: rtl/pcie_msi_resp.sv
// MSI responder: request/ack handshake, capability masking, pending replay and descriptor output.
// Optional counters stat_sent/stat_dropped are built when PCIE_MSI_RESP_STATS_EN is defined.
module pcie_msi_resp
  import pcie_msi_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 app_msi_req,
  input  logic [MSI_VEC_W-1:0] app_msi_num,
  input  logic [2:0]           app_msi_tc,
  output logic                 app_msi_ack,
  input  logic                 msi_en,
  input  logic [2:0]           msi_mme,
  input  logic [63:0]          msi_addr,
  input  logic [15:0]          msi_data,
  input  logic [MSI_NVEC-1:0]  msi_mask,
  output logic [MSI_NVEC-1:0]  msi_pending,
  output logic                 msg_valid,
  input  logic                 msg_ready,
  output logic [63:0]          msg_addr,
  output logic [31:0]          msg_data,
  output logic [2:0]           msg_tc
`ifdef PCIE_MSI_RESP_STATS_EN
  ,
  output logic [31:0]          stat_sent,
  output logic [31:0]          stat_dropped
`endif
);

  msi_resp_state_t state_reg, state_next;

  logic                 ack_reg;
  logic                 valid_reg;
  logic [63:0]          addr_reg;
  logic [31:0]          data_reg;
  logic [2:0]           tc_reg;
  logic                 owed_reg;
  logic [MSI_VEC_W-1:0] vec_reg;

  logic [2:0]           m_eff;
  logic [MSI_VEC_W-1:0] req_vec;
  logic                 load;
  logic [MSI_VEC_W-1:0] ld_vec;
  logic [2:0]           ld_tc;
  logic                 set_en;
  logic                 clr_en;
  logic                 drop_evt;
  logic                 sent_evt;
  logic                 arb_any;
  logic [MSI_VEC_W-1:0] arb_idx;

  assign m_eff   = msi_eff_mme(msi_mme);
  assign req_vec = app_msi_num & msi_vec_mask(m_eff);

  pcie_msi_pend_arb u_pend_arb (
    .clk     (clk),
    .rst     (reset),
    .set_en  (set_en),
    .set_idx (req_vec),
    .clr_en  (clr_en),
    .clr_idx (vec_reg),
    .mask    (msi_mask),
    .pending (msi_pending),
    .any     (arb_any),
    .idx     (arb_idx)
  );

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    set_en     = 1'b0;
    clr_en     = 1'b0;
    drop_evt   = 1'b0;
    sent_evt   = 1'b0;
    ld_vec     = arb_idx;
    ld_tc      = 3'd0;
    case (state_reg)
      IDLE: begin
        if (app_msi_req) begin
          ld_vec = req_vec;
          ld_tc  = app_msi_tc;
          if (!msi_en) begin
            drop_evt   = 1'b1;
            state_next = ACK;
          end else if (msi_mask[req_vec]) begin
            set_en     = 1'b1;
            state_next = ACK;
          end else begin
            load       = 1'b1;
            state_next = EMIT;
          end
        end else if (msi_en && arb_any) begin
          load       = 1'b1;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (msg_ready) begin
          sent_evt = 1'b1;
          if (owed_reg) begin
            state_next = ACK;
          end else begin
            clr_en     = 1'b1;
            state_next = IDLE;
          end
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      ack_reg   <= 1'b0;
      valid_reg <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
      tc_reg    <= '0;
      owed_reg  <= 1'b0;
      vec_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= (state_next == ACK);
      valid_reg <= (state_next == EMIT);
      if (load) begin
        addr_reg <= msi_addr;
        data_reg <= msi_merge_data(msi_data, m_eff, ld_vec);
        tc_reg   <= ld_tc;
        owed_reg <= app_msi_req;
        vec_reg  <= ld_vec;
      end
    end
  end

  assign app_msi_ack = ack_reg;
  assign msg_valid   = valid_reg;
  assign msg_addr    = addr_reg;
  assign msg_data    = data_reg;
  assign msg_tc      = tc_reg;

`ifdef PCIE_MSI_RESP_STATS_EN
  logic [31:0] sent_reg;
  logic [31:0] dropped_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sent_reg    <= '0;
      dropped_reg <= '0;
    end else begin
      if (sent_evt) sent_reg <= sent_reg + 32'd1;
      if (drop_evt) dropped_reg <= dropped_reg + 32'd1;
    end
  end

  assign stat_sent    = sent_reg;
  assign stat_dropped = dropped_reg;
`else
  logic unused_evt;
  assign unused_evt = sent_evt ^ drop_evt;
`endif

endmodule

// File: tb/tb_pcie_msi_resp.sv
// Directed bench for pcie_msi_resp; also checks the counters when PCIE_MSI_RESP_STATS_EN is defined.
module tb_pcie_msi_resp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        app_msi_req = 1'b0;
  logic [4:0]  app_msi_num = '0;
  logic [2:0]  app_msi_tc = '0;
  logic        app_msi_ack;
  logic        msi_en = 1'b0;
  logic [2:0]  msi_mme = '0;
  logic [63:0] msi_addr = '0;
  logic [15:0] msi_data = '0;
  logic [31:0] msi_mask = '0;
  logic [31:0] msi_pending;
  logic        msg_valid;
  logic        msg_ready = 1'b0;
  logic [63:0] msg_addr;
  logic [31:0] msg_data;
  logic [2:0]  msg_tc;
`ifdef PCIE_MSI_RESP_STATS_EN
  logic [31:0] stat_sent;
  logic [31:0] stat_dropped;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] ADDR = 64'h1234_5678_9ABC_DEF0;

  always #5 clk = ~clk;

  pcie_msi_resp dut (
    .clk         (clk),
    .reset       (reset),
    .app_msi_req (app_msi_req),
    .app_msi_num (app_msi_num),
    .app_msi_tc  (app_msi_tc),
    .app_msi_ack (app_msi_ack),
    .msi_en      (msi_en),
    .msi_mme     (msi_mme),
    .msi_addr    (msi_addr),
    .msi_data    (msi_data),
    .msi_mask    (msi_mask),
    .msi_pending (msi_pending),
    .msg_valid   (msg_valid),
    .msg_ready   (msg_ready),
    .msg_addr    (msg_addr),
    .msg_data    (msg_data),
    .msg_tc      (msg_tc)
`ifdef PCIE_MSI_RESP_STATS_EN
    ,
    .stat_sent    (stat_sent),
    .stat_dropped (stat_dropped)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic start_req(input logic [4:0] num, input logic [2:0] tc);
    app_msi_num = num;
    app_msi_tc  = tc;
    app_msi_req = 1'b1;
    $display("txn req num=%0d tc=%0d en=%0b mme=%0d mask=%h", num, tc, msi_en, msi_mme, msi_mask);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!msg_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, msg_valid, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ack", app_msi_ack, 0);
    chk("rst_valid", msg_valid, 0);
    chk("rst_pending", msi_pending, 0);
    chk("rst_addr", msg_addr, 0);
    chk("rst_data", msg_data, 0);
    chk("rst_tc", msg_tc, 0);
    reset = 1'b0;
    @(negedge clk);

    // Delivered request, ack two cycles after sampling
    msi_en = 1'b1; msi_mme = 3'd3; msi_data = 16'hAB00; msi_addr = ADDR; msg_ready = 1'b1;
    start_req(5'd5, 3'd2);
    @(negedge clk);
    chk("t1_valid", msg_valid, 1);
    chk("t1_data", msg_data, 32'h0000AB05);
    chk("t1_addr", msg_addr, ADDR);
    chk("t1_tc", msg_tc, 3'd2);
    chk("t1_noack", app_msi_ack, 0);
    @(negedge clk);
    chk("t1_ack", app_msi_ack, 1);
    chk("t1_valid_off", msg_valid, 0);
    app_msi_req = 1'b0;
    @(negedge clk);
    chk("t1_ack_pulse", app_msi_ack, 0);

    // Vector truncation and backpressure
    msi_mme = 3'd1; msg_ready = 1'b0;
    start_req(5'd7, 3'd1);
    @(negedge clk);
    chk("t2_valid", msg_valid, 1);
    chk("t2_data", msg_data, 32'h0000AB01);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_hold_valid", msg_valid, 1);
      chk("t2_hold_data", msg_data, 32'h0000AB01);
      chk("t2_hold_noack", app_msi_ack, 0);
    end
    msg_ready = 1'b1;
    @(negedge clk);
    chk("t2_ack", app_msi_ack, 1);
    app_msi_req = 1'b0;
    @(negedge clk);

    // Masked request goes pending, then replays once unmasked
    msi_mme = 3'd3; msi_mask = 32'h8;
    start_req(5'd3, 3'd0);
    @(negedge clk);
    chk("t3_ack", app_msi_ack, 1);
    chk("t3_novalid", msg_valid, 0);
    chk("t3_pending", msi_pending, 32'h8);
    app_msi_req = 1'b0;
    @(negedge clk);
    chk("t3_still_masked", msg_valid, 0);
    chk("t3_pending_hold", msi_pending, 32'h8);
    msi_mask = 32'h0;
    @(negedge clk);
    chk("t3_replay_valid", msg_valid, 1);
    chk("t3_replay_data", msg_data, 32'h0000AB03);
    chk("t3_replay_tc", msg_tc, 0);
    chk("t3_replay_noack", app_msi_ack, 0);
    @(negedge clk);
    chk("t3_replay_done", msg_valid, 0);
    chk("t3_pending_clr", msi_pending, 0);
    chk("t3_noack", app_msi_ack, 0);

    // Disabled: dropped with ack
    msi_en = 1'b0;
    start_req(5'd2, 3'd0);
    @(negedge clk);
    chk("t4_ack", app_msi_ack, 1);
    chk("t4_novalid", msg_valid, 0);
    chk("t4_pending", msi_pending, 0);
`ifdef PCIE_MSI_RESP_STATS_EN
    chk("t4_dropped", stat_dropped, 1);
    chk("t4_sent", stat_sent, 3);
`endif
    app_msi_req = 1'b0;
    @(negedge clk);
    chk("t4_novalid2", msg_valid, 0);
    msi_en = 1'b1;

    // Request beats replay; then pending replays in index order
    msi_mask = 32'h12;
    start_req(5'd1, 3'd0);
    @(negedge clk);
    chk("t5_ack1", app_msi_ack, 1);
    app_msi_req = 1'b0;
    @(negedge clk);
    start_req(5'd4, 3'd0);
    @(negedge clk);
    chk("t5_ack4", app_msi_ack, 1);
    app_msi_req = 1'b0;
    @(negedge clk);
    chk("t5_pending", msi_pending, 32'h12);
    msi_mask = 32'h0;
    start_req(5'd0, 3'd5);
    @(negedge clk);
    chk("t5_v0_valid", msg_valid, 1);
    chk("t5_v0_data", msg_data, 32'h0000AB00);
    chk("t5_v0_tc", msg_tc, 3'd5);
    @(negedge clk);
    chk("t5_v0_ack", app_msi_ack, 1);
    app_msi_req = 1'b0;
    @(negedge clk);
    wait_valid("t5_r1_valid", 5);
    chk("t5_r1_data", msg_data, 32'h0000AB01);
    chk("t5_r1_tc", msg_tc, 0);
    chk("t5_r1_noack", app_msi_ack, 0);
    @(negedge clk);
    chk("t5_pending_after1", msi_pending, 32'h10);
    wait_valid("t5_r4_valid", 5);
    chk("t5_r4_data", msg_data, 32'h0000AB04);
    @(negedge clk);
    chk("t5_pending_after4", msi_pending, 0);
    chk("t5_idle", msg_valid, 0);
`ifdef PCIE_MSI_RESP_STATS_EN
    chk("t5_sent", stat_sent, 6);
`endif

    // Asynchronous reset while emitting
    msi_mask = 32'h4;
    start_req(5'd2, 3'd0);
    @(negedge clk);
    chk("t6_ack_masked", app_msi_ack, 1);
    app_msi_req = 1'b0;
    @(negedge clk);
    chk("t6_pending", msi_pending, 32'h4);
    msg_ready = 1'b0;
    start_req(5'd6, 3'd3);
    @(negedge clk);
    chk("t6_valid", msg_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_valid", msg_valid, 0);
    chk("t6_rst_pending", msi_pending, 0);
    chk("t6_rst_ack", app_msi_ack, 0);
    app_msi_req = 1'b0;
    @(negedge clk);
    reset = 1'b0; msi_mask = 32'h0; msg_ready = 1'b1;
    @(negedge clk);
    chk("t6_post_idle", msg_valid, 0);
    start_req(5'd9, 3'd1);
    @(negedge clk);
    chk("t6_post_valid", msg_valid, 1);
    chk("t6_post_data", msg_data, 32'h0000AB01);
    chk("t6_post_tc", msg_tc, 3'd1);
    @(negedge clk);
    chk("t6_post_ack", app_msi_ack, 1);
    app_msi_req = 1'b0;
    @(negedge clk);
    chk("t6_post_ack_off", app_msi_ack, 0);
`ifdef PCIE_MSI_RESP_STATS_EN
    chk("t6_sent", stat_sent, 1);
    chk("t6_dropped", stat_dropped, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pcie_msi_resp.md
# pcie_msi_resp

Hard-IP-side MSI responder and bus-functional model for the application MSI handshake. Accepts `app_msi_req`/`app_msi_num`/`app_msi_tc` from an MSI requester and returns a one-cycle `app_msi_ack`. Applies MSI capability state (enable, multiple-message-enable, address/data, per-vector mask) and emits one memory-write message descriptor per delivered interrupt. Sits where the PCIe core would; used in simulation benches and as the RTL model of the core's MSI path.

## Interface
- Parameters: none; widths come from `pcie_msi_pkg`.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  sole clock
- `reset`  in  1  asynchronous, active-high reset
- `app_msi_req`  in  1  request; held high until ack
- `app_msi_num`  in  5  requested vector
- `app_msi_tc`  in  3  traffic class
- `app_msi_ack`  out  1  one-cycle acknowledge
- `msi_en`  in  1  MSI enable (capability bit)
- `msi_mme`  in  3  multiple-message-enable, log2 of vectors granted
- `msi_addr`  in  64  message address
- `msi_data`  in  16  message data base
- `msi_mask`  in  32  per-vector mask
- `msi_pending`  out  32  per-vector pending bits
- `msg_valid`  out  1  descriptor valid
- `msg_ready`  in  1  descriptor accept
- `msg_addr`  out  64  write address
- `msg_data`  out  32  write data
- `msg_tc`  out  3  traffic class of the write

## Operation
- FSM states: IDLE, EMIT, ACK.
- Effective mme: `m = min(msi_mme, 5)`. Effective vector: `v = app_msi_num & ((1<<m)-1)`. Upper bits are silently truncated.
- Message data is `{16'h0, msi_data}` with bits `[m-1:0]` replaced by `v[m-1:0]`. `msg_addr = msi_addr`.
- IDLE with `app_msi_req=1`:
  - `!msi_en` → ACK; request dropped; pending unchanged.
  - `msi_en && msi_mask[v]` → set `msi_pending[v]`, → ACK.
  - Otherwise → EMIT, with the descriptor latched from that cycle's inputs, tagged "ack-owed".
- IDLE with no request, `msi_en=1`, and `msi_pending & ~msi_mask != 0` → EMIT the lowest set index, tagged "replay", with `msg_tc=0`.
- A new request has priority over replay in the same cycle.
- EMIT: `msg_valid=1`. The descriptor is stable until `msg_ready`. On `msg_valid && msg_ready`:
  - ack-owed → ACK.
  - replay → clear that pending bit, → IDLE.
- ACK: `app_msi_ack=1` for exactly one cycle, then → IDLE.
- The requester deasserts `app_msi_req` in the cycle after ack; IDLE never sees the stale request.
- Masking or unmasking a vector while a replay is in EMIT does not retract the descriptor.
- Pending bits survive `msi_en` deassertion and are replayed once it is re-enabled.
- Capability inputs are sampled only at the IDLE→EMIT transition.

## Timing
- Reset values:
  - `app_msi_ack=0`, `msg_valid=0`, `msi_pending=0`, `msg_addr=0`, `msg_data=0`, `msg_tc=0`.
  - State IDLE.
  - Asserting reset mid-EMIT drops `msg_valid` immediately (asynchronously).
- Request sampled in IDLE at cycle 0:
  - Delivered: `msg_valid` high at cycle 1. If `msg_ready` is high at cycle k≥1, ack is at cycle k+1. Minimum request-to-ack latency is 2 cycles.
  - Masked or disabled: ack at cycle 1.
- Back-to-back requests: the next request can be sampled at ack+2, in the IDLE cycle following the request drop.
- Replay: `msg_valid` the cycle after IDLE detects an eligible pending bit. The bit clears on the accept edge.
- All outputs are registered.

## Configuration
- `PCIE_MSI_RESP_STATS_EN` defined:
  - Adds output `stat_sent` (32): increments on every accepted descriptor, both ack-owed and replay.
  - Adds output `stat_dropped` (32): increments on every request acked while `!msi_en`.
  - Both counters wrap modulo 2^32 and reset to 0.
- Macro not defined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- `pcie_msi_pkg`:
  - `MSI_VEC_W=5`, `MSI_NVEC=32`, `MSI_MME_MAX=5`.
  - The state enum `msi_resp_state_t`.
  - A function computing the merged message data from `msi_data`, `m` and `v`.
- Sub-module `pcie_msi_pend_arb`:
  - Holds the 32-bit pending register with set/clear ports.
  - Produces the lowest-index eligible vector (`pending & ~mask`) and an `any` flag.

## Test plan
- `msi_en=1`, `mme=3`, `msi_data=16'hAB00`, request vector 5, `msg_ready` held high → one descriptor with `msg_data=32'h0000AB05` and `msg_addr=msi_addr`; ack 2 cycles after the request is sampled.
- `mme=1`, request vector 7 → `msg_data` low bit =1 (vector truncated to 1); `msg_ready` held low for 10 cycles → `msg_valid` and the descriptor stay stable and no ack is given until `msg_ready` rises.
- `msi_mask[3]=1`, request vector 3 → ack at cycle 1, no descriptor, `msi_pending=32'h8`. Clear the mask → one replay descriptor with vector 3, no ack, and `msi_pending` returns to 0.
- `msi_en=0`, request vector 2 → ack at cycle 1, no descriptor, pending unchanged; `stat_dropped` increments to 1 when `PCIE_MSI_RESP_STATS_EN` is defined.
- Pending bits 1 and 4 unmasked while a request for vector 0 arrives in the same cycle → vector 0 is emitted and acked first, then replays for 1 and then 4.
- Assert reset while in EMIT → `msg_valid` low immediately, `msi_pending=0`; after reset, a fresh request is handled normally.
